// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth partial-product accumulator.
// Optional flush port is enabled by defining BOOTH_PP_ACCUM_FLUSH_EN.
package booth_pkg;

   typedef enum logic [0:0] {
      ACC  = 1'b0,
      DONE = 1'b1
   } state_t;

   localparam int DEF_WIDTH = 16;
   localparam int NUM_PP    = DEF_WIDTH / 2;
   localparam int ACC_W     = 2 * DEF_WIDTH + 2;

   // Widest operand the helper supports; callers sign-extend into it and keep the low bits.
   localparam int MAX_W     = 128;

   // Sign-extended partial product plus its correction bit, weighted by 4^idx.
   function automatic logic [2*MAX_W+1:0] pp_term(input logic [MAX_W:0] pp_sext,
                                                  input logic           comp,
                                                  input int unsigned    idx);
      logic [2*MAX_W+1:0] wide;
      wide = {{(MAX_W+1){pp_sext[MAX_W]}}, pp_sext};
      return (wide + {{(2*MAX_W+1){1'b0}}, comp}) << (2 * idx);
   endfunction

endpackage

// File: rtl/booth_pp_shift.sv
// Combinational weighting of one selected partial product into accumulator width.
// Used by booth_pp_accum (optional flush via BOOTH_PP_ACCUM_FLUSH_EN lives in the top).
module booth_pp_shift
   import booth_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH:0]               pp_in,
   input  logic                         pp_comp,
   input  logic [$clog2(WIDTH/2)-1:0]   idx,
   output logic [2*WIDTH+1:0]           term
);

   logic [MAX_W:0]     pp_sext_s;
   logic [2*MAX_W+1:0] term_wide_s;
   logic               unused_hi_s;

   // Widen, weight, then keep only the accumulator-width slice; upper wrap is discarded.
   always_comb begin
      pp_sext_s   = {{(MAX_W-WIDTH){pp_in[WIDTH]}}, pp_in};
      term_wide_s = pp_term(pp_sext_s, pp_comp, 32'(idx));
      term        = term_wide_s[2*WIDTH+1:0];
      unused_hi_s = ^term_wide_s[2*MAX_W+1:2*WIDTH+2];
   end

endmodule

// File: rtl/booth_pp_accum.sv
// Sequential radix-4 Booth partial-product accumulator with valid/ready product output.
// Define BOOTH_PP_ACCUM_FLUSH_EN to add a synchronous flush input.
module booth_pp_accum
   import booth_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = $clog2(WIDTH/2)
) (
   input  logic                 clk,
   input  logic                 rst,
`ifdef BOOTH_PP_ACCUM_FLUSH_EN
   input  logic                 flush,
`endif
   input  logic                 pp_valid,
   output logic                 pp_ready,
   input  logic [WIDTH:0]       pp_in,
   input  logic                 pp_comp,
   output logic                 prod_valid,
   input  logic                 prod_ready,
   output logic [2*WIDTH-1:0]   prod,
   output logic                 busy
);

   localparam int             SUM_W    = 2 * WIDTH + 2;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH/2 - 1);

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic [SUM_W-1:0]    acc_q, acc_d;
   logic                pp_ready_q;
   logic                prod_valid_q;
   logic                busy_q;
   logic [2*WIDTH-1:0]  prod_q;
   logic [SUM_W-1:0]    term_s;
   logic                beat_s;

   booth_pp_shift #(.WIDTH(WIDTH)) u_shift (
      .pp_in   (pp_in),
      .pp_comp (pp_comp),
      .idx     (idx_q),
      .term    (term_s)
   );

   // Next-state: accumulate beats in ACC, hold the product in DONE until it is taken.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      beat_s  = pp_valid & pp_ready_q;
      case (state_q)
         ACC: begin
            if (beat_s) begin
               acc_d = acc_q + term_s;
               if (idx_q == LAST_IDX) begin
                  idx_d   = {CNT_W{1'b0}};
                  state_d = DONE;
               end else begin
                  idx_d = idx_q + CNT_W'(1);
               end
            end else begin
               acc_d = acc_q;
            end
         end
         DONE: begin
            if (prod_valid_q & prod_ready) begin
               acc_d   = {SUM_W{1'b0}};
               state_d = ACC;
            end else begin
               acc_d = acc_q;
            end
         end
         default: begin
            state_d = ACC;
            idx_d   = {CNT_W{1'b0}};
            acc_d   = {SUM_W{1'b0}};
         end
      endcase
`ifdef BOOTH_PP_ACCUM_FLUSH_EN
      // Flush overrides anything decided above, including a beat presented this cycle.
      if (flush) begin
         state_d = ACC;
         idx_d   = {CNT_W{1'b0}};
         acc_d   = {SUM_W{1'b0}};
      end else begin
         state_d = state_d;
      end
`endif
   end

   // State and registered outputs, all derived from the next-state values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ACC;
         idx_q        <= {CNT_W{1'b0}};
         acc_q        <= {SUM_W{1'b0}};
         pp_ready_q   <= 1'b1;
         prod_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         prod_q       <= {(2*WIDTH){1'b0}};
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         acc_q        <= acc_d;
         pp_ready_q   <= (state_d == ACC);
         prod_valid_q <= (state_d == DONE);
         busy_q       <= (state_d == DONE) || (idx_d != {CNT_W{1'b0}});
         prod_q       <= acc_d[2*WIDTH-1:0];
      end
   end

   assign pp_ready   = pp_ready_q;
   assign prod_valid = prod_valid_q;
   assign busy       = busy_q;
   assign prod       = prod_q;

endmodule

// File: tb/tb_booth_pp_accum.sv
// Scoreboard bench for booth_pp_accum: Booth digits are generated from random operands
// and the expected product is the plain signed multiply of those operands.
module tb_booth_pp_accum;

   localparam int W = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            pp_valid = 1'b0;
   logic            pp_ready;
   logic [W:0]      pp_in = '0;
   logic            pp_comp = 1'b0;
   logic            prod_valid;
   logic            prod_ready = 1'b1;
   logic [2*W-1:0]  prod;
   logic            busy;
`ifdef BOOTH_PP_ACCUM_FLUSH_EN
   logic            flush = 1'b0;
`endif

   always #5 clk = ~clk;

   booth_pp_accum #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
`ifdef BOOTH_PP_ACCUM_FLUSH_EN
      .flush      (flush),
`endif
      .pp_valid   (pp_valid),
      .pp_ready   (pp_ready),
      .pp_in      (pp_in),
      .pp_comp    (pp_comp),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .prod       (prod),
      .busy       (busy)
   );

   int           chk_cnt = 0;
   int           pass_cnt = 0;
   logic [31:0]  exp_q[$];
   bit           rdy_rand = 1'b0;

   logic [16:0] v1_pp[8] = '{17'h1FFFC, 17'h1FFFC, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
   logic        v1_c [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [16:0] v2_pp[8] = '{17'h1FFF1, 17'h0000E, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0};
   logic        v2_c [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Monitor: pop and compare on every product handshake; also check stall stability.
   logic        prev_stall = 1'b0;
   logic [31:0] prev_prod  = '0;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", 64'(prod_valid), 64'd1);
            check("hold_prod", 64'(prod), 64'(prev_prod));
         end
         if (prod_valid && prod_ready) begin
            if (exp_q.size() == 0) begin
               chk_cnt++;
               $display("FAIL spurious_prod: got %h expected no product", prod);
            end else begin
               check("prod", 64'(prod), 64'(exp_q.pop_front()));
            end
         end
         prev_stall = prod_valid && !prod_ready;
         prev_prod  = prod;
      end
   end

   always @(posedge clk) begin
      if (rdy_rand) begin
         #1;
         prod_ready = 1'($urandom_range(0, 1));
      end
   end

   // Called at posedge+1; returns at posedge+1 after the beat was taken.
   task automatic send_beat(input logic [16:0] pp, input logic c, input bit gap);
      if (gap) begin
         pp_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(posedge clk);
         #1;
      end
      pp_valid = 1'b1;
      pp_in    = pp;
      pp_comp  = c;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (pp_ready) begin
            @(posedge clk);
            #1;
            pp_valid = 1'b0;
            return;
         end
      end
      chk_cnt++;
      $display("FAIL beat_timeout: got pp_ready=0 for 200 cycles expected 1");
      pp_valid = 1'b0;
   endtask

   task automatic send_seq(input int which, input int nbeats, input bit toggle);
      for (int i = 0; i < nbeats; i++) begin
         if (which == 1) send_beat(v1_pp[i], v1_c[i], toggle && (i % 2 == 1));
         else            send_beat(v2_pp[i], v2_c[i], toggle && (i % 2 == 1));
      end
   endtask

   // Upstream Booth select stage for digit i of multiplier b applied to multiplicand a.
   task automatic booth_digit(input logic [15:0] a, input logic [15:0] b, input int i,
                              output logic [16:0] pp, output logic c);
      logic [16:0] bx;
      logic [2:0]  t;
      bx = {b, 1'b0};
      t  = bx[2*i+2 -: 3];
      case (t)
         3'b001, 3'b010: begin pp = {a[15], a};     c = 1'b0; end
         3'b011:         begin pp = {a, 1'b0};      c = 1'b0; end
         3'b100:         begin pp = ~{a, 1'b0};     c = 1'b1; end
         3'b101, 3'b110: begin pp = ~{a[15], a};    c = 1'b1; end
         default:        begin pp = 17'h0;          c = 1'b0; end
      endcase
   endtask

   task automatic run_mult(input logic [15:0] a, input logic [15:0] b, input bit gaps);
      int          pa, pb;
      logic [16:0] pp;
      logic        c;
      pa = int'($signed(a));
      pb = int'($signed(b));
      exp_q.push_back(32'(pa * pb));
      for (int i = 0; i < W/2; i++) begin
         booth_digit(a, b, i, pp, c);
         send_beat(pp, c, gaps && ($urandom_range(0, 3) == 0));
      end
   endtask

   task automatic wait_idle();
      for (int t = 0; t < 500; t++) begin
         if (exp_q.size() == 0) return;
         @(posedge clk);
      end
      chk_cnt++;
      $display("FAIL drain_timeout: got %0d pending products expected 0", exp_q.size());
   endtask

   initial begin
      logic [15:0] ra, rb;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_pp_ready", 64'(pp_ready), 64'd1);
      check("rst_prod_valid", 64'(prod_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_prod", 64'(prod), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // 3 * -5, product one cycle after the last beat
      exp_q.push_back(32'hFFFFFFF1);
      send_seq(1, 8, 1'b0);
      @(negedge clk);
      check("latency_valid", 64'(prod_valid), 64'd1);
      wait_idle();
      @(posedge clk); #1;

      // 7 * 6
      exp_q.push_back(32'h0000002A);
      send_seq(2, 8, 1'b0);
      wait_idle();
      @(posedge clk); #1;

      // 3 * -5 with pp_valid toggling
      exp_q.push_back(32'hFFFFFFF1);
      send_seq(1, 8, 1'b1);
      wait_idle();
      @(posedge clk); #1;

      // Backpressure with new data pending upstream
      prod_ready = 1'b0;
      exp_q.push_back(32'hFFFFFFF1);
      exp_q.push_back(32'h0000002A);
      send_seq(1, 8, 1'b0);
      @(negedge clk);
      check("bp_busy", 64'(busy), 64'd1);
      @(posedge clk); #1;
      for (int k = 0; k < 5; k++) begin
         pp_valid = 1'b1;
         pp_in    = 17'($urandom);
         pp_comp  = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("bp_pp_ready", 64'(pp_ready), 64'd0);
         check("bp_prod", 64'(prod), 64'hFFFFFFF1);
         @(posedge clk); #1;
      end
      pp_valid   = 1'b0;
      prod_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("post_hs_busy", 64'(busy), 64'd0);
      check("post_hs_pp_ready", 64'(pp_ready), 64'd1);
      check("post_hs_acc", 64'(prod), 64'd0);
      @(posedge clk); #1;
      send_seq(2, 8, 1'b0);
      wait_idle();
      @(posedge clk); #1;

      // Reset after beat 3, then 7 * 6
      send_seq(1, 4, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_pp_ready", 64'(pp_ready), 64'd1);
      check("midrst_valid", 64'(prod_valid), 64'd0);
      check("midrst_prod", 64'(prod), 64'd0);
      @(posedge clk); #1;
      exp_q.push_back(32'h0000002A);
      send_seq(2, 8, 1'b0);
      wait_idle();
      @(posedge clk); #1;

`ifdef BOOTH_PP_ACCUM_FLUSH_EN
      // Flush after beat 5 with a beat presented in the flush cycle
      send_seq(1, 6, 1'b0);
      flush    = 1'b1;
      pp_valid = 1'b1;
      pp_in    = 17'h1FFFF;
      pp_comp  = 1'b1;
      @(posedge clk); #1;
      flush    = 1'b0;
      pp_valid = 1'b0;
      @(negedge clk);
      check("flush_busy", 64'(busy), 64'd0);
      check("flush_prod", 64'(prod), 64'd0);
      @(posedge clk); #1;
      exp_q.push_back(32'h0000002A);
      send_seq(2, 8, 1'b0);
      wait_idle();
      @(posedge clk); #1;
`endif

      // Random operands, corners first, with gaps and random backpressure
      rdy_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         case (n)
            0:       begin ra = 16'h8000; rb = 16'h8000; end
            1:       begin ra = 16'h7FFF; rb = 16'h8000; end
            2:       begin ra = 16'h8000; rb = 16'h7FFF; end
            3:       begin ra = 16'hFFFF; rb = 16'hFFFF; end
            4:       begin ra = 16'h0000; rb = 16'hA5A5; end
            default: begin ra = 16'($urandom); rb = 16'($urandom); end
         endcase
         run_mult(ra, rb, n[0]);
      end
      wait_idle();
      rdy_rand = 1'b0;
      @(posedge clk); #1;
      prod_ready = 1'b1;
      repeat (3) @(posedge clk);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
